bc_rx_mem_arb: RTL and testbench
================================

BC_RX_MEM_ARB -- requirements
Module: bc_rx_mem_arb

Interface
REQ-001 Parameter MEM_AWIDTH, default 16: SRAM word-address width.
REQ-002 Parameter RD_LATENCY, default 2, legal values 1 or 2: cycles from the mem_ren cycle to mem_rdata valid.
REQ-003 Parameter MAX_BURST, default 8, range 1..255: maximum consecutive locked grants to one requester while the other is waiting.
REQ-004 Port HCLK, input, 1: the only clock; all logic is on its rising edge.
REQ-005 Port HRESETN, input, 1: reset, synchronous, active-low.
REQ-006 Ports reqN_valid, input, 1 (N=0,1): requester N presents an access.
REQ-007 Ports reqN_write, input, 1: 1 = write, 0 = read.
REQ-008 Ports reqN_addr, input, MEM_AWIDTH: word address.
REQ-009 Ports reqN_wdata, input, 32: write data.
REQ-010 Ports reqN_byteen, input, 4: write byte enables.
REQ-011 Ports reqN_lock, input, 1: keep the grant for the next access.
REQ-012 Ports reqN_ready, output, 1: access accepted at this edge when reqN_valid and reqN_ready are both 1.
REQ-013 Ports rspN_valid, output, 1: read data valid for requester N, one-cycle pulse.
REQ-014 Ports rspN_rdata, output, 32: read data for requester N.
REQ-015 Ports mem_ren and mem_wen, output, 1 each: SRAM read and write strobes.
REQ-016 Port mem_addr, output, MEM_AWIDTH: SRAM word address.
REQ-017 Port mem_byteen, output, 4: SRAM byte enables.
REQ-018 Port mem_wdata, output, 32: SRAM write data.
REQ-019 Port mem_rdata, input, 32: SRAM read data.

Function
REQ-020 The arbiter FSM SHALL have three states: IDLE, OWN0 and OWN1.
- A grant (reqN_ready) is a combinational function of the state, the valid inputs, the round-robin pointer and the burst counter.

REQ-021 In IDLE or on a non-locked access, arbitration SHALL be round-robin:
- Only one requester valid: it is granted.
- Both valid: the requester not granted last is granted.
- After reset the pointer favours requester 0.

REQ-022 An access accepted with reqN_lock=1 SHALL move or keep the FSM in OWNn.
- An access with lock=0 returns the FSM to IDLE.
- An edge with no acceptance while in OWNn (owner not valid) returns the FSM to IDLE.

REQ-023 In OWNn, only requester N SHALL be granted, except as set out in REQ-024.

REQ-024 The burst counter SHALL behave as follows:
- It counts accepted accesses while in OWNn.
- It clears on entry to OWNn and in IDLE.
- When it reaches MAX_BURST and the other requester is valid, the FSM goes to IDLE and the other requester is granted on the next cycle.
- When the other requester is idle, the counter saturates and the lock is honoured.

REQ-025 Each accepted access SHALL be issued on the mem_* outputs, all registered, in the cycle following the accepting edge.
- The strobe is mem_wen or mem_ren according to reqN_write.
- Both strobes are 0 in any cycle without an issued access.
- mem_byteen is 4'hF on reads.

REQ-026 Accesses SHALL be issued one per cycle with no bubbles.
- Back-to-back accepts give back-to-back strobes, for sustained full throughput.

REQ-027 Read ownership SHALL be tracked with a RD_LATENCY+1 deep tag pipeline.
- For a read accepted at edge E, the block captures mem_rdata at edge E+1+RD_LATENCY.
- rspN_valid is then 1 for exactly the following cycle, with rspN_rdata equal to the captured word.

REQ-028 Responses SHALL return in acceptance order per requester.
- rsp0_valid and rsp1_valid SHALL never both be 1 in the same cycle.

REQ-029 rspN_rdata SHALL hold its last value when rspN_valid=0.

REQ-030 Requesters SHALL hold their request fields stable while valid and not ready; the arbiter does not check this.

Reset
REQ-031 While HRESETN=0 at an edge, the block SHALL reset as follows:
- FSM goes to IDLE; pointer favours requester 0; burst counter 0; tag pipeline cleared.
- All outputs 0 from the next cycle: ready, rsp, mem strobes, address, byteen, wdata and rdata.
- reqN_ready is forced to 0 while HRESETN=0.

REQ-032 Reads in flight at reset SHALL be discarded, and no rspN_valid follows for them.

Verification
REQ-033 Both requesters issue continuous non-locked reads -> grants alternate 0,1,0,1. With RD_LATENCY=2, the rsp pulse occurs 4 cycles after acceptance.

REQ-034 Requester 0 writes addr 0x0010, data 0xA5A5_5A5A, byteen 4'b0011 -> for one cycle: mem_wen=1, mem_addr=0x0010, mem_byteen=4'b0011, mem_ren=0.

REQ-035 Requester 1 locked with MAX_BURST=4 while requester 0 waits -> requester 1 gets exactly 4 consecutive grants, then requester 0 is granted next.

REQ-036 Requester 0 locked and alone for 20 accesses -> all 20 are granted back-to-back with no forced switch.

REQ-037 Reset asserted one cycle after a read is accepted, RD_LATENCY=1 -> no rsp0_valid, mem strobes 0, and the first post-reset grant goes to requester 0 when both are valid.

REQ-038 Interleaved reads 0,1,0 with RD_LATENCY=1 -> rsp0, rsp1, rsp0 on consecutive cycles, each carrying the mem_rdata of its own address.

Source files
------------

// File: rtl/bc_rx_mem_arb.sv
// ---------------------------------------------------------------------------
// bc_rx_mem_arb
// Two-requester arbiter in front of a single-port synchronous SRAM.
//   - Round-robin arbitration with optional lock (burst ownership), limited
//     to MAX_BURST consecutive grants while the other requester waits.
//   - Accepted accesses are issued on registered mem_* outputs one cycle
//     after acceptance, one per cycle with no bubbles.
//   - Reads are tracked with a RD_LATENCY+1 deep tag pipeline so the read
//     data is routed back to the requester that issued it.
//
// Ports
//   HCLK, HRESETN            clock, synchronous active-low reset
//   reqN_valid/write/addr/wdata/byteen/lock   request from requester N
//   reqN_ready               combinational grant (accept when valid&ready)
//   rspN_valid/rdata         registered read response, one-cycle pulse
//   mem_ren/wen/addr/byteen/wdata   registered SRAM command
//   mem_rdata                SRAM read data, valid RD_LATENCY cycles after ren
// ---------------------------------------------------------------------------
module bc_rx_mem_arb #(
  parameter int MEM_AWIDTH = 16,
  parameter int RD_LATENCY = 2,
  parameter int MAX_BURST  = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [MEM_AWIDTH-1:0] req0_addr,
  input  logic [31:0]           req0_wdata,
  input  logic [3:0]            req0_byteen,
  input  logic                  req0_lock,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [MEM_AWIDTH-1:0] req1_addr,
  input  logic [31:0]           req1_wdata,
  input  logic [3:0]            req1_byteen,
  input  logic                  req1_lock,
  output logic                  req1_ready,
  output logic                  rsp0_valid,
  output logic [31:0]           rsp0_rdata,
  output logic                  rsp1_valid,
  output logic [31:0]           rsp1_rdata,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [MEM_AWIDTH-1:0] mem_addr,
  output logic [3:0]            mem_byteen,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;
  localparam int         TAGD    = RD_LATENCY + 1;

  logic [1:0]            r_state;
  logic                  r_last;      // requester granted most recently
  logic [7:0]            r_burst;     // accepts counted while in OWNn
  logic                  r_mem_ren;
  logic                  r_mem_wen;
  logic [MEM_AWIDTH-1:0] r_mem_addr;
  logic [3:0]            r_mem_byteen;
  logic [31:0]           r_mem_wdata;
  logic [TAGD-1:0]       r_tag_vld;
  logic [TAGD-1:0]       r_tag_id;
  logic                  r_rsp0_valid;
  logic                  r_rsp1_valid;
  logic [31:0]           r_rsp0_rdata;
  logic [31:0]           r_rsp1_rdata;

  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_acc0;
  logic                  w_acc1;
  logic                  w_acc;
  logic                  w_sel;
  logic                  w_write;
  logic                  w_lock;
  logic                  w_other_valid;
  logic [MEM_AWIDTH-1:0] w_addr;
  logic [31:0]           w_wdata;
  logic [3:0]            w_byteen;
  logic [8:0]            w_burst_len;
  logic                  w_release;
  logic [1:0]            w_state_nxt;
  logic [7:0]            w_burst_nxt;

  // Grant selection: round-robin in IDLE, owner-only while locked.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req0_valid && req1_valid) begin
          w_gnt0 = r_last;
          w_gnt1 = ~r_last;
        end else begin
          w_gnt0 = req0_valid;
          w_gnt1 = req1_valid;
        end
      end
      ST_OWN0: w_gnt0 = req0_valid;
      ST_OWN1: w_gnt1 = req1_valid;
      default: begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
      end
    endcase
  end

  assign req0_ready = HRESETN & w_gnt0;
  assign req1_ready = HRESETN & w_gnt1;
  assign w_acc0     = req0_valid & req0_ready;
  assign w_acc1     = req1_valid & req1_ready;
  assign w_acc      = w_acc0 | w_acc1;
  assign w_sel      = w_acc1;

  assign w_write       = w_sel ? req1_write  : req0_write;
  assign w_lock        = w_sel ? req1_lock   : req0_lock;
  assign w_addr        = w_sel ? req1_addr   : req0_addr;
  assign w_wdata       = w_sel ? req1_wdata  : req0_wdata;
  assign w_byteen      = w_sel ? req1_byteen : req0_byteen;
  assign w_other_valid = w_sel ? req0_valid  : req1_valid;

  // Length of the current burst including this accept: the entry grant is
  // made from IDLE, so the OWN-state count is offset by one.
  assign w_burst_len = (r_state == ST_IDLE) ? 9'd1 : ({1'b0, r_burst} + 9'd2);
  assign w_release   = (w_burst_len >= 9'(MAX_BURST)) && w_other_valid;

  // Next-state and burst-count computation.
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_burst_nxt = 8'd0;
    if (w_acc && w_lock && !w_release) begin
      w_state_nxt = w_sel ? ST_OWN1 : ST_OWN0;
      if (r_state == ST_IDLE) begin
        w_burst_nxt = 8'd0;
      end else if (r_burst == 8'hFF) begin
        w_burst_nxt = r_burst;
      end else begin
        w_burst_nxt = r_burst + 8'd1;
      end
    end else begin
      w_state_nxt = ST_IDLE;
      w_burst_nxt = 8'd0;
    end
  end

  // Arbitration state, round-robin pointer and burst counter.
  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_burst <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_burst <= w_burst_nxt;
      if (w_acc) begin
        r_last <= w_sel;
      end
    end
  end

  // SRAM command issue, registered one cycle after acceptance.
  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      r_mem_ren    <= 1'b0;
      r_mem_wen    <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_byteen <= 4'd0;
      r_mem_wdata  <= 32'd0;
    end else begin
      r_mem_ren <= w_acc & ~w_write;
      r_mem_wen <= w_acc & w_write;
      if (w_acc) begin
        r_mem_addr   <= w_addr;
        r_mem_byteen <= w_write ? w_byteen : 4'hF;
        r_mem_wdata  <= w_wdata;
      end
    end
  end

  // Read tag pipeline and response capture; stage RD_LATENCY lines up with
  // the edge where mem_rdata for that read is valid.
  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      r_tag_vld    <= '0;
      r_tag_id     <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_rdata <= 32'd0;
      r_rsp1_rdata <= 32'd0;
    end else begin
      r_tag_vld    <= {r_tag_vld[TAGD-2:0], w_acc & ~w_write};
      r_tag_id     <= {r_tag_id[TAGD-2:0], w_sel};
      r_rsp0_valid <= r_tag_vld[TAGD-1] & ~r_tag_id[TAGD-1];
      r_rsp1_valid <= r_tag_vld[TAGD-1] & r_tag_id[TAGD-1];
      if (r_tag_vld[TAGD-1] && !r_tag_id[TAGD-1]) begin
        r_rsp0_rdata <= mem_rdata;
      end
      if (r_tag_vld[TAGD-1] && r_tag_id[TAGD-1]) begin
        r_rsp1_rdata <= mem_rdata;
      end
    end
  end

  assign mem_ren    = r_mem_ren;
  assign mem_wen    = r_mem_wen;
  assign mem_addr   = r_mem_addr;
  assign mem_byteen = r_mem_byteen;
  assign mem_wdata  = r_mem_wdata;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp0_rdata = r_rsp0_rdata;
  assign rsp1_rdata = r_rsp1_rdata;

endmodule

// File: tb/tb_bc_rx_mem_arb.sv
// ---------------------------------------------------------------------------
// tb_bc_rx_mem_arb
// Scoreboard bench for bc_rx_mem_arb (RD_LATENCY=1, MAX_BURST=4). Two queue
// driven requesters, a behavioural SRAM returning a fixed function of the
// address, and a negedge monitor that checks mem commands, response data,
// response latency and grant order.
// ---------------------------------------------------------------------------
module tb_bc_rx_mem_arb;
  localparam int AW = 16;
  localparam int RL = 1;
  localparam int MB = 4;

  logic          HCLK = 1'b0;
  logic          HRESETN;
  logic          req0_valid, req0_write, req0_lock, req0_ready;
  logic          req1_valid, req1_write, req1_lock, req1_ready;
  logic [AW-1:0] req0_addr, req1_addr, mem_addr;
  logic [31:0]   req0_wdata, req1_wdata, mem_wdata, mem_rdata;
  logic [3:0]    req0_byteen, req1_byteen, mem_byteen;
  logic          rsp0_valid, rsp1_valid, mem_ren, mem_wen;
  logic [31:0]   rsp0_rdata, rsp1_rdata;

  always #5 HCLK = ~HCLK;

  bc_rx_mem_arb #(.MEM_AWIDTH(AW), .RD_LATENCY(RL), .MAX_BURST(MB)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_byteen(req0_byteen), .req0_lock(req0_lock),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_byteen(req1_byteen), .req1_lock(req1_lock),
    .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_byteen(mem_byteen), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic          wr;
    logic          lk;
    logic [AW-1:0] addr;
    logic [31:0]   wd;
    logic [3:0]    be;
  } txn_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } rsp_t;

  txn_t  q0[$], q1[$];
  rsp_t  e0[$], e1[$];
  int    glog[$], clog[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  logic  acc0 = 1'b0, acc1 = 1'b0;
  logic  mon_en = 1'b0;
  logic  rst_prev = 1'b1;
  logic  op_pend = 1'b0;
  txn_t  op_exp, t_mon;
  rsp_t  r_mon;
  logic [31:0] last0 = 32'd0, last1 = 32'd0;
  logic [31:0] mpipe [0:RL-1];

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [AW-1:0] a);
    return {~a, a} ^ 32'h1357_9BDF;
  endfunction

  function automatic txn_t mk(input logic wr, input logic lk, input logic [AW-1:0] a,
                              input logic [31:0] d, input logic [3:0] be);
    txn_t t;
    t.wr = wr; t.lk = lk; t.addr = a; t.wd = d; t.be = be;
    return t;
  endfunction

  // Behavioural SRAM: data for a read strobe appears RL cycles later.
  always @(posedge HCLK) begin
    mpipe[0] <= mem_ren ? mem_f(mem_addr) : 32'hDEAD_BEEF;
    for (int i = 1; i < RL; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mem_rdata = mpipe[RL-1];

  // Requester 0 driver: hold the head of q0 until accepted.
  initial begin
    req0_valid = 1'b0; req0_write = 1'b0; req0_lock = 1'b0;
    req0_addr = '0; req0_wdata = 32'd0; req0_byteen = 4'd0;
    forever begin
      @(posedge HCLK); #1;
      if (acc0) void'(q0.pop_front());
      if (q0.size() > 0) begin
        req0_valid = 1'b1; req0_write = q0[0].wr; req0_lock = q0[0].lk;
        req0_addr = q0[0].addr; req0_wdata = q0[0].wd; req0_byteen = q0[0].be;
      end else begin
        req0_valid = 1'b0;
      end
    end
  end

  // Requester 1 driver.
  initial begin
    req1_valid = 1'b0; req1_write = 1'b0; req1_lock = 1'b0;
    req1_addr = '0; req1_wdata = 32'd0; req1_byteen = 4'd0;
    forever begin
      @(posedge HCLK); #1;
      if (acc1) void'(q1.pop_front());
      if (q1.size() > 0) begin
        req1_valid = 1'b1; req1_write = q1[0].wr; req1_lock = q1[0].lk;
        req1_addr = q1[0].addr; req1_wdata = q1[0].wd; req1_byteen = q1[0].be;
      end else begin
        req1_valid = 1'b0;
      end
    end
  end

  // Monitor / scoreboard, sampled mid-cycle.
  always @(negedge HCLK) begin
    if (mon_en) begin
      cyc++;
      if (rst_prev) begin
        check_val("rst_mem", {mem_ren, mem_wen, mem_addr, mem_byteen}, 64'd0);
        check_val("rst_wdata", mem_wdata, 64'd0);
        check_val("rst_rsp", {rsp0_valid, rsp1_valid}, 64'd0);
        check_val("rst_rdata", {rsp0_rdata, rsp1_rdata}, 64'd0);
        last0 = 32'd0; last1 = 32'd0;
      end else if (op_pend) begin
        check_val("mem_wen", mem_wen, op_exp.wr);
        check_val("mem_ren", mem_ren, !op_exp.wr);
        check_val("mem_addr", mem_addr, op_exp.addr);
        check_val("mem_byteen", mem_byteen, op_exp.wr ? op_exp.be : 4'hF);
        if (op_exp.wr) check_val("mem_wdata", mem_wdata, op_exp.wd);
      end else begin
        check_val("mem_idle", {mem_ren, mem_wen}, 64'd0);
      end

      check_val("rsp_excl", rsp0_valid & rsp1_valid, 64'd0);
      if (rsp0_valid) begin
        if (e0.size() == 0) check_val("rsp0_unexp", 1'b1, 1'b0);
        else begin
          r_mon = e0.pop_front();
          check_val("rsp0_data", rsp0_rdata, r_mon.data);
          check_val("rsp0_lat", cyc, r_mon.cyc + 2 + RL);
        end
        last0 = rsp0_rdata;
      end else if (!rst_prev) check_val("rsp0_hold", rsp0_rdata, last0);
      if (rsp1_valid) begin
        if (e1.size() == 0) check_val("rsp1_unexp", 1'b1, 1'b0);
        else begin
          r_mon = e1.pop_front();
          check_val("rsp1_data", rsp1_rdata, r_mon.data);
          check_val("rsp1_lat", cyc, r_mon.cyc + 2 + RL);
        end
        last1 = rsp1_rdata;
      end else if (!rst_prev) check_val("rsp1_hold", rsp1_rdata, last1);

      if (!HRESETN) check_val("rst_ready", {req0_ready, req1_ready}, 64'd0);
      acc0 = req0_valid & req0_ready;
      acc1 = req1_valid & req1_ready;
      if (acc0 || acc1) check_val("one_grant", acc0 & acc1, 64'd0);
      op_pend = acc0 | acc1;
      if (acc0 || acc1) begin
        if (acc1) begin
          t_mon = mk(req1_write, req1_lock, req1_addr, req1_wdata, req1_byteen);
          glog.push_back(1);
        end else begin
          t_mon = mk(req0_write, req0_lock, req0_addr, req0_wdata, req0_byteen);
          glog.push_back(0);
        end
        clog.push_back(cyc);
        op_exp = t_mon;
        if (!t_mon.wr) begin
          r_mon.data = mem_f(t_mon.addr);
          r_mon.cyc  = cyc;
          if (acc1) e1.push_back(r_mon);
          else e0.push_back(r_mon);
        end
      end
      if (!HRESETN) begin
        e0.delete(); e1.delete();
      end
      rst_prev = !HRESETN;
    end
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || e0.size() != 0 || e1.size() != 0) && n < 300) begin
      @(negedge HCLK);
      n++;
    end
    check_val({tag, "_drain"}, (n < 300), 1'b1);
    repeat (4) @(negedge HCLK);
  endtask

  task automatic check_seq(input string tag, input int exp_g[$]);
    check_val({tag, "_n"}, glog.size(), exp_g.size());
    for (int i = 0; i < exp_g.size() && i < glog.size(); i++) begin
      check_val({tag, "_gnt"}, glog[i], exp_g[i]);
      check_val({tag, "_b2b"}, clog[i], clog[0] + i);
    end
  endtask

  initial begin
    int g[$];
    int n;
    HRESETN = 1'b0;
    @(posedge HCLK);
    mon_en = 1'b1;
    repeat (2) @(posedge HCLK);
    #1 HRESETN = 1'b1;

    // Continuous non-locked reads from both: strict alternation from 0.
    @(negedge HCLK);
    glog.delete(); clog.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b0, 1'b0, 16'h0100 + 16'(i), 32'd0, 4'd0));
      q1.push_back(mk(1'b0, 1'b0, 16'h0200 + 16'(i), 32'd0, 4'd0));
    end
    wait_idle("alt");
    g = '{0, 1, 0, 1, 0, 1, 0, 1};
    check_seq("alt", g);

    // Single partial-byte write from requester 0.
    glog.delete(); clog.delete();
    q0.push_back(mk(1'b1, 1'b0, 16'h0010, 32'hA5A5_5A5A, 4'b0011));
    wait_idle("wr");
    g = '{0};
    check_seq("wr", g);

    // Requester 1 locked while requester 0 waits: burst capped at MB.
    glog.delete(); clog.delete();
    for (int i = 0; i < 6; i++) q1.push_back(mk(1'b0, 1'b1, 16'h0300 + 16'(i), 32'd0, 4'd0));
    q0.push_back(mk(1'b0, 1'b0, 16'h0400, 32'd0, 4'd0));
    wait_idle("burst");
    g = '{1, 1, 1, 1, 0, 1, 1};
    check_seq("burst", g);

    // Requester 0 locked and alone for 20 accesses.
    glog.delete(); clog.delete();
    g.delete();
    for (int i = 0; i < 20; i++) begin
      q0.push_back(mk(1'b0, 1'b1, 16'h0500 + 16'(i), 32'd0, 4'd0));
      g.push_back(0);
    end
    wait_idle("lock20");
    check_seq("lock20", g);

    // Reset one cycle after a read is accepted: the read is dropped.
    glog.delete(); clog.delete();
    @(negedge HCLK);
    q0.push_back(mk(1'b0, 1'b0, 16'h0600, 32'd0, 4'd0));
    n = 0;
    while (glog.size() == 0 && n < 50) begin
      @(posedge HCLK);
      n++;
    end
    check_val("rst_acc_wait", (n < 50), 1'b1);
    #1 HRESETN = 1'b0;
    repeat (2) @(posedge HCLK);
    #1 HRESETN = 1'b1;
    repeat (4) @(negedge HCLK);
    glog.delete(); clog.delete();
    q0.push_back(mk(1'b0, 1'b0, 16'h0700, 32'd0, 4'd0));
    q1.push_back(mk(1'b0, 1'b0, 16'h0800, 32'd0, 4'd0));
    wait_idle("postrst");
    g = '{0, 1};
    check_seq("postrst", g);

    // Interleaved reads 0,1,0: responses on consecutive cycles.
    glog.delete(); clog.delete();
    q0.push_back(mk(1'b0, 1'b0, 16'h0900, 32'd0, 4'd0));
    q0.push_back(mk(1'b0, 1'b0, 16'h0902, 32'd0, 4'd0));
    q1.push_back(mk(1'b0, 1'b0, 16'h0A00, 32'd0, 4'd0));
    wait_idle("ilv");
    g = '{0, 1, 0};
    check_seq("ilv", g);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
